yarvi_commit: RTL

- Commit/writeback stage of the yarvi RV64I pipeline. It sits after yarvi_me and consumes the retirement stream: priv, pc, insn, wb_rd and wb_val.
- Maintains the architectural instret and cycle counters, with a CSR write port for each.
- Buffers every retirement in a parametrised trace FIFO behind a valid/ready handshake. The consumer is the disassembler, a tracer or a lockstep checker.
- The core pipeline has no backpressure. On overflow the block drops entries, counts them, and flags the loss.

---
 rtl/yarvi_commit_pkg.sv | 16 +
 rtl/yarvi_trace_fifo.sv | 49 ++++
 rtl/yarvi_commit.sv | 106 ++++++++++
 3 files changed

// File: rtl/yarvi_commit_pkg.sv
// Commit-stage constants: trace-entry field widths and the packed entry width.
// Shared by the commit stage and anything that unpacks its trace stream.
package yarvi_commit_pkg;

    localparam int PRIV_W = 2;
    localparam int INSN_W = 32;
    localparam int RD_W   = 5;
    localparam int LOST_W = 1;
    localparam int DROP_W = 32;

    // Packed entry layout, MSB first: priv, pc, insn, rd, val, seq, lost.
    function automatic int trace_w(input int vlen, input int xlen, input int seq_w);
        return PRIV_W + vlen + INSN_W + RD_W + xlen + seq_w + LOST_W;
    endfunction

endpackage

// File: rtl/yarvi_trace_fifo.sv
// Generic DEPTH x WIDTH FIFO, synchronous write and combinational read at the head.
// Latency 1 cycle push-to-head (no bypass); caller gates push/pop against full/empty.
module yarvi_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdat,
    output logic [WIDTH-1:0] rdat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + (AW+1)'(1);
        if (pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdat  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wdat;
    end

endmodule

// File: rtl/yarvi_commit.sv
// Commit stage: instret/cycle counters plus a retirement trace FIFO; trace entries 1 cycle after retire.
// The pipeline cannot stall, so a full FIFO drops retirements, counts them and tags the next entry.
module yarvi_commit
    import yarvi_commit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int VLEN  = 64,
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              me_valid,
    input  logic [PRIV_W-1:0] me_priv,
    input  logic [VLEN-1:0]   me_pc,
    input  logic [INSN_W-1:0] me_insn,
    input  logic [RD_W-1:0]   me_wb_rd,
    input  logic [XLEN-1:0]   me_wb_val,
    input  logic              csr_instret_we,
    input  logic              csr_cycle_we,
    input  logic [XLEN-1:0]   csr_wdata,
    output logic [XLEN-1:0]   instret,
    output logic [XLEN-1:0]   cycle,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [PRIV_W-1:0] tr_priv,
    output logic [VLEN-1:0]   tr_pc,
    output logic [INSN_W-1:0] tr_insn,
    output logic [RD_W-1:0]   tr_rd,
    output logic [XLEN-1:0]   tr_val,
    output logic [SEQ_W-1:0]  tr_seq,
    output logic              tr_lost,
    output logic [DROP_W-1:0] drop_count
);

    localparam int TW = trace_w(VLEN, XLEN, SEQ_W);

    logic [XLEN-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]   cycle_q, cycle_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              lost_q, lost_d;

    logic              fifo_full, fifo_empty;
    logic              push, pop, drop;
    logic [XLEN-1:0]   wb_val_m;
    logic [TW-1:0]     push_dat, head_dat;

    assign tr_valid = !fifo_empty;
    assign pop      = tr_valid && tr_ready;
    assign push     = me_valid && (!fifo_full || pop);
    assign drop     = me_valid && fifo_full && !pop;

    assign wb_val_m = (me_wb_rd == '0) ? '0 : me_wb_val;
    // Sequence number is the instret value before this retirement is counted.
    assign push_dat = {me_priv, me_pc, me_insn, me_wb_rd, wb_val_m,
                       instret_q[SEQ_W-1:0], lost_q};

    always_comb begin
        cycle_d      = csr_cycle_we ? csr_wdata : cycle_q + XLEN'(1);
        instret_d    = instret_q;
        drop_count_d = drop_count_q;
        lost_d       = lost_q;
        if (csr_instret_we)  instret_d = csr_wdata;
        else if (me_valid)   instret_d = instret_q + XLEN'(1);
        if (drop) begin
            lost_d = 1'b1;
            if (drop_count_q != '1) drop_count_d = drop_count_q + DROP_W'(1);
        end else if (push) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            instret_q    <= '0;
            cycle_q      <= '0;
            drop_count_q <= '0;
            lost_q       <= 1'b0;
        end else begin
            instret_q    <= instret_d;
            cycle_q      <= cycle_d;
            drop_count_q <= drop_count_d;
            lost_q       <= lost_d;
        end
    end

    yarvi_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdat  (push_dat),
        .rdat  (head_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {tr_priv, tr_pc, tr_insn, tr_rd, tr_val, tr_seq, tr_lost} = head_dat;
    assign instret    = instret_q;
    assign cycle      = cycle_q;
    assign drop_count = drop_count_q;

endmodule
